// File: rtl/vga_tx_engine.sv
// vga_tx_engine: programmable VGA timing generator with line-buffer readout,
// integer pixel/line replication, ping-pong bank select and test patterns.
// Pipeline: stage 0 counters/address, stage 1 RAM data, stage 2 registered RGB.
module vga_tx_engine #(
   parameter int unsigned H_VISIBLE = 1024,
   parameter int unsigned H_FP      = 24,
   parameter int unsigned H_SYNC    = 136,
   parameter int unsigned H_BP      = 160,
   parameter int unsigned V_VISIBLE = 768,
   parameter int unsigned V_FP      = 3,
   parameter int unsigned V_SYNC    = 6,
   parameter int unsigned V_BP      = 29,
   parameter int unsigned HS_POL    = 0,
   parameter int unsigned VS_POL    = 0,
   parameter int unsigned PIX_REP   = 2,
   parameter int unsigned LINE_REP  = 2,
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned DATA_W    = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ENABLE,
   input  logic [1:0]        MODE,
   input  logic              SYNC_EN,
   output logic [ADDR_W-1:0] BRAM_ADDR,
   input  logic [DATA_W-1:0] BRAM_DOUT,
   output logic [DATA_W-1:0] VGA_R,
   output logic [DATA_W-1:0] VGA_G,
   output logic [DATA_W-1:0] VGA_B,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              VGA_VISIBLE,
   output logic              VGA_SYNC
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
   localparam int unsigned HW1     = HW + 1;
   localparam int unsigned VW1     = VW + 1;
   localparam int unsigned XW      = ADDR_W - 1;
   localparam int unsigned PRW     = (PIX_REP > 1) ? $clog2(PIX_REP) : 1;
   localparam int unsigned LRW     = (LINE_REP > 1) ? $clog2(LINE_REP) : 1;
   localparam int unsigned BAR_W   = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
   localparam int unsigned BSW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [HW1-1:0] H_VIS_END = HW1'(H_VISIBLE);
   localparam logic [HW1-1:0] HS_START  = HW1'(H_VISIBLE + H_FP);
   localparam logic [HW1-1:0] HS_STOP   = HW1'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [VW1-1:0] V_VIS_END = VW1'(V_VISIBLE);
   localparam logic [VW1-1:0] VS_START  = VW1'(V_VISIBLE + V_FP);
   localparam logic [VW1-1:0] VS_STOP   = VW1'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [PRW-1:0] PR_LAST   = PRW'(PIX_REP - 1);
   localparam logic [LRW-1:0] LR_LAST   = LRW'(LINE_REP - 1);
   localparam logic [BSW-1:0] BS_LAST   = BSW'(BAR_W - 1);
   localparam logic [XW-1:0]  X_MAX     = '1;
   localparam logic           HS_ACT    = (HS_POL != 0);
   localparam logic           VS_ACT    = (VS_POL != 0);

   typedef enum logic [1:0] {
      MODE_BUF   = 2'b00,
      MODE_BARS  = 2'b01,
      MODE_GRID  = 2'b10,
      MODE_BLACK = 2'b11
   } mode_e;

   // stage 0 state
   logic [HW-1:0]     r_h_cnt;
   logic [VW-1:0]     r_v_cnt;
   logic [PRW-1:0]    r_px_rep;
   logic [XW-1:0]     r_src_x;
   logic [LRW-1:0]    r_ln_rep;
   logic [VW-1:0]     r_src_y;
   logic [BSW-1:0]    r_bar_sub;
   logic [2:0]        r_bar;
   mode_e             r_mode;

   // stage 1 state
   logic              r_s1_vis;
   logic              r_s1_hs;
   logic              r_s1_vs;
   logic              r_s1_sync;
   logic              r_s1_grid;
   logic [2:0]        r_s1_bar;
   logic [DATA_W-1:0] r_dout_hold;
   logic              r_use_hold;

   // stage 2 state
   logic [DATA_W-1:0] r_vga_r;
   logic [DATA_W-1:0] r_vga_g;
   logic [DATA_W-1:0] r_vga_b;
   logic              r_s2_vis;
   logic              r_s2_hs;
   logic              r_s2_vs;
   logic              r_s2_sync;

   logic              w_h_last;
   logic              w_v_last;
   logic              w_frame0;
   logic [HW1-1:0]    w_h_ext;
   logic [VW1-1:0]    w_v_ext;
   logic              w_vis;
   logic              w_hs_act;
   logic              w_vs_act;
   logic              w_h_grid;
   logic              w_v_grid;
   logic [DATA_W-1:0] w_pix;
   logic [DATA_W-1:0] w_r;
   logic [DATA_W-1:0] w_g;
   logic [DATA_W-1:0] w_b;

   assign w_h_last = (r_h_cnt == H_LAST);
   assign w_v_last = (r_v_cnt == V_LAST);
   assign w_frame0 = (r_h_cnt == '0) && (r_v_cnt == '0);
   assign w_h_ext  = {1'b0, r_h_cnt};
   assign w_v_ext  = {1'b0, r_v_cnt};
   assign w_vis    = (w_h_ext < H_VIS_END) && (w_v_ext < V_VIS_END);
   assign w_hs_act = (w_h_ext >= HS_START) && (w_h_ext < HS_STOP);
   assign w_vs_act = (w_v_ext >= VS_START) && (w_v_ext < VS_STOP);

   generate
      if (HW >= 4) begin : g_hgrid
         assign w_h_grid = (r_h_cnt[3:0] == 4'd0);
      end else begin : g_hgrid_narrow
         assign w_h_grid = (r_h_cnt == '0);
      end
      if (VW >= 4) begin : g_vgrid
         assign w_v_grid = (r_v_cnt[3:0] == 4'd0);
      end else begin : g_vgrid_narrow
         assign w_v_grid = (r_v_cnt == '0);
      end
   endgenerate

   // Read from the bank opposite the one being filled by the receive side.
   assign BRAM_ADDR = {~r_src_y[0], r_src_x};

   // Horizontal and vertical raster counters.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (ENABLE) begin
         if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
         end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
         end
      end
   end

   // Pixel and line replication; src_x saturates so it never wraps within a line.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_px_rep <= '0;
         r_src_x  <= '0;
         r_ln_rep <= '0;
         r_src_y  <= '0;
      end else if (ENABLE) begin
         if (w_h_last) begin
            r_px_rep <= '0;
            r_src_x  <= '0;
            if (w_v_last) begin
               r_ln_rep <= '0;
               r_src_y  <= '0;
            end else if (r_ln_rep == LR_LAST) begin
               r_ln_rep <= '0;
               r_src_y  <= r_src_y + 1'b1;
            end else begin
               r_ln_rep <= r_ln_rep + 1'b1;
            end
         end else if (r_px_rep == PR_LAST) begin
            r_px_rep <= '0;
            if (r_src_x != X_MAX) begin
               r_src_x <= r_src_x + 1'b1;
            end
         end else begin
            r_px_rep <= r_px_rep + 1'b1;
         end
      end
   end

   // Colour-bar index: steps every H_VISIBLE/8 clocks, restarts each line.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_bar_sub <= '0;
         r_bar     <= '0;
      end else if (ENABLE) begin
         if (w_h_last) begin
            r_bar_sub <= '0;
            r_bar     <= '0;
         end else if (r_bar_sub == BS_LAST) begin
            r_bar_sub <= '0;
            if (r_bar != 3'd7) begin
               r_bar <= r_bar + 1'b1;
            end
         end else begin
            r_bar_sub <= r_bar_sub + 1'b1;
         end
      end
   end

   // Pattern mode is latched only at the first pixel of a frame.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_mode <= MODE_BUF;
      end else if (ENABLE && w_frame0) begin
         r_mode <= mode_e'(MODE);
      end
   end

   // While stalled the RAM keeps reading the held stage-0 address, so the
   // stage-1 word is captured on the first stalled edge and replayed on resume.
   assign w_pix = r_use_hold ? r_dout_hold : BRAM_DOUT;

   // Stage-2 colour selection.
   always_comb begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
      if (r_s1_vis) begin
         case (r_mode)
            MODE_BUF: begin
               w_r = w_pix;
               w_g = w_pix;
               w_b = w_pix;
            end
            MODE_BARS: begin
               w_r = {DATA_W{r_s1_bar[2]}};
               w_g = {DATA_W{r_s1_bar[1]}};
               w_b = {DATA_W{r_s1_bar[0]}};
            end
            MODE_GRID: begin
               if (r_s1_grid) begin
                  w_r = '1;
                  w_g = '1;
                  w_b = '1;
               end
            end
            default: begin
               w_r = '0;
            end
         endcase
      end
   end

   // Stage 1 and stage 2 pipeline registers plus stall data hold.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_s1_vis    <= 1'b0;
         r_s1_hs     <= ~HS_ACT;
         r_s1_vs     <= ~VS_ACT;
         r_s1_sync   <= 1'b0;
         r_s1_grid   <= 1'b0;
         r_s1_bar    <= '0;
         r_dout_hold <= '0;
         r_use_hold  <= 1'b0;
         r_vga_r     <= '0;
         r_vga_g     <= '0;
         r_vga_b     <= '0;
         r_s2_vis    <= 1'b0;
         r_s2_hs     <= ~HS_ACT;
         r_s2_vs     <= ~VS_ACT;
         r_s2_sync   <= 1'b0;
      end else if (ENABLE) begin
         r_s1_vis   <= w_vis;
         r_s1_hs    <= w_hs_act ? HS_ACT : ~HS_ACT;
         r_s1_vs    <= w_vs_act ? VS_ACT : ~VS_ACT;
         r_s1_sync  <= w_frame0 && SYNC_EN;
         r_s1_grid  <= w_h_grid || w_v_grid;
         r_s1_bar   <= r_bar;
         r_use_hold <= 1'b0;
         r_vga_r    <= w_r;
         r_vga_g    <= w_g;
         r_vga_b    <= w_b;
         r_s2_vis   <= r_s1_vis;
         r_s2_hs    <= r_s1_hs;
         r_s2_vs    <= r_s1_vs;
         r_s2_sync  <= r_s1_sync;
      end else if (!r_use_hold) begin
         r_dout_hold <= BRAM_DOUT;
         r_use_hold  <= 1'b1;
      end
   end

   assign VGA_R       = r_vga_r;
   assign VGA_G       = r_vga_g;
   assign VGA_B       = r_vga_b;
   assign VGA_HS      = r_s2_hs;
   assign VGA_VS      = r_s2_vs;
   assign VGA_VISIBLE = r_s2_vis;
   assign VGA_SYNC    = r_s2_sync;

endmodule

// File: tb/tb_vga_tx_engine.sv
// tb_vga_tx_engine: two engine instances sharing control inputs.
// Instance A: H 8/2/2/4, V 4/1/1/2, no replication (timing, mode, stall, reset).
// Instance B: H 16/2/2/4, V 4/1/1/2, 2x2 replication (table-driven patterns).
module tb_vga_tx_engine;

   logic        CLK;
   logic        RESET;
   logic        ENABLE;
   logic [1:0]  MODE;
   logic        SYNC_EN;

   logic [13:0] a_addr;
   logic [7:0]  a_dout;
   logic [7:0]  a_r, a_g, a_b;
   logic        a_hs, a_vs, a_vis, a_sync;

   logic [13:0] b_addr;
   logic [7:0]  b_dout;
   logic [7:0]  b_r, b_g, b_b;
   logic        b_hs, b_vs, b_vis, b_sync;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   vga_tx_engine #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .HS_POL(0), .VS_POL(0), .PIX_REP(1), .LINE_REP(1),
      .ADDR_W(14), .DATA_W(8)
   ) u_a (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .MODE(MODE), .SYNC_EN(SYNC_EN),
      .BRAM_ADDR(a_addr), .BRAM_DOUT(a_dout),
      .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
      .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_VISIBLE(a_vis), .VGA_SYNC(a_sync)
   );

   vga_tx_engine #(
      .H_VISIBLE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .HS_POL(0), .VS_POL(0), .PIX_REP(2), .LINE_REP(2),
      .ADDR_W(14), .DATA_W(8)
   ) u_b (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .MODE(MODE), .SYNC_EN(SYNC_EN),
      .BRAM_ADDR(b_addr), .BRAM_DOUT(b_dout),
      .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
      .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_VISIBLE(b_vis), .VGA_SYNC(b_sync)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Free-running line buffers with 1-cycle registered read, data = addr[7:0].
   always @(posedge CLK) begin
      a_dout <= a_addr[7:0];
      b_dout <= b_addr[7:0];
   end

   typedef struct {
      logic [1:0]  mode;
      int unsigned cyc;
      logic [13:0] addr;
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
      logic        vis;
   } vec_t;

   vec_t tbl [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   // Instance A expectation for cycle n after reset release (state n drives the
   // address, state n-2 drives the video outputs; 128-clock frame).
   function automatic void exp_a(input int unsigned n, input bit black, input bit sen,
                                 output logic [13:0] e_addr, output logic [3:0] e_ctl,
                                 output logic [7:0] e_pix);
      int unsigned st, s, h, v;
      logic hs, vs, vis, sy;
      st = n % 128;
      h  = st % 16;
      v  = st / 16;
      e_addr = ((v % 2) == 0) ? (14'h2000 | 14'(h)) : 14'(h);
      s  = (n + 126) % 128;
      h  = s % 16;
      v  = s / 16;
      hs  = !(h >= 10 && h < 12);
      vs  = (v != 5);
      vis = (h < 8) && (v < 4);
      sy  = sen && (s == 0);
      e_ctl = {hs, vs, vis, sy};
      e_pix = (vis && !black) ? 8'(h) : 8'h00;
   endfunction

   task automatic chk_a(input string tag, input int unsigned n, input bit black, input bit sen);
      logic [13:0] ea;
      logic [3:0]  ec;
      logic [7:0]  ep;
      exp_a(n, black, sen, ea, ec, ep);
      chk($sformatf("%s_addr@%0d", tag, n), 32'(a_addr), 32'(ea));
      chk($sformatf("%s_hs_vs_vis_sync@%0d", tag, n), 32'({a_hs, a_vs, a_vis, a_sync}), 32'(ec));
      chk($sformatf("%s_rgb@%0d", tag, n), 32'({a_r, a_g, a_b}), 32'({ep, ep, ep}));
   endtask

   task automatic chk_a_reset(input string tag);
      chk($sformatf("%s_addr", tag), 32'(a_addr), 32'h2000);
      chk($sformatf("%s_hs_vs_vis_sync", tag), 32'({a_hs, a_vs, a_vis, a_sync}), 32'b1100);
      chk($sformatf("%s_rgb", tag), 32'({a_r, a_g, a_b}), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned sync_cnt;

      tbl[0]  = '{2'b01,   2, 14'h2001, 8'h00, 8'h00, 8'h00, 1'b1};
      tbl[1]  = '{2'b01,   9, 14'h2004, 8'h00, 8'hFF, 8'hFF, 1'b1};
      tbl[2]  = '{2'b01,  12, 14'h2006, 8'hFF, 8'h00, 8'hFF, 1'b1};
      tbl[3]  = '{2'b01,  13, 14'h2006, 8'hFF, 8'h00, 8'hFF, 1'b1};
      tbl[4]  = '{2'b01,  14, 14'h2007, 8'hFF, 8'hFF, 8'h00, 1'b1};
      tbl[5]  = '{2'b01,  17, 14'h2008, 8'hFF, 8'hFF, 8'hFF, 1'b1};
      tbl[6]  = '{2'b01,  18, 14'h2009, 8'h00, 8'h00, 8'h00, 1'b0};
      tbl[7]  = '{2'b01,  28, 14'h2002, 8'h00, 8'h00, 8'hFF, 1'b1};
      tbl[8]  = '{2'b00,   5, 14'h2002, 8'h01, 8'h01, 8'h01, 1'b1};
      tbl[9]  = '{2'b00,   6, 14'h2003, 8'h02, 8'h02, 8'h02, 1'b1};
      tbl[10] = '{2'b00,   7, 14'h2003, 8'h02, 8'h02, 8'h02, 1'b1};
      tbl[11] = '{2'b00,  17, 14'h2008, 8'h07, 8'h07, 8'h07, 1'b1};
      tbl[12] = '{2'b00,  30, 14'h2003, 8'h02, 8'h02, 8'h02, 1'b1};
      tbl[13] = '{2'b00,  50, 14'h0001, 8'h00, 8'h00, 8'h00, 1'b1};
      tbl[14] = '{2'b00,  80, 14'h0004, 8'h03, 8'h03, 8'h03, 1'b1};
      tbl[15] = '{2'b00, 100, 14'h2002, 8'h00, 8'h00, 8'h00, 1'b0};
      tbl[16] = '{2'b10,   5, 14'h2002, 8'hFF, 8'hFF, 8'hFF, 1'b1};
      tbl[17] = '{2'b10,  30, 14'h2003, 8'h00, 8'h00, 8'h00, 1'b1};
      tbl[18] = '{2'b10,  26, 14'h2001, 8'hFF, 8'hFF, 8'hFF, 1'b1};
      tbl[19] = '{2'b11,  12, 14'h2006, 8'h00, 8'h00, 8'h00, 1'b1};

      RESET   = 1'b1;
      ENABLE  = 1'b1;
      MODE    = 2'b00;
      SYNC_EN = 1'b1;

      // Two full frames of instance A timing, buffer mode.
      do_reset();
      chk_a_reset("a_reset_state");
      sync_cnt = 0;
      for (int unsigned n = 0; n < 260; n++) begin
         chk_a("a_run", n, 1'b0, 1'b1);
         if (a_sync) sync_cnt++;
         tick();
      end
      chk("a_sync_count", 32'(sync_cnt), 32'd3);

      // Mode change mid-frame only takes effect at the next frame start.
      do_reset();
      repeat (40) tick();
      MODE = 2'b11;
      for (int unsigned n = 40; n < 141; n++) begin
         chk_a("a_modechg", n, (n >= 130), 1'b1);
         tick();
      end
      MODE = 2'b00;

      // ENABLE low for 5 clocks mid-line: outputs freeze, then resume.
      do_reset();
      repeat (20) tick();
      chk_a("a_prestall", 20, 1'b0, 1'b1);
      ENABLE = 1'b0;
      for (int unsigned k = 0; k < 5; k++) begin
         tick();
         chk_a("a_stall", 20, 1'b0, 1'b1);
      end
      ENABLE = 1'b1;
      for (int unsigned k = 1; k <= 40; k++) begin
         tick();
         chk_a("a_resume", 20 + k, 1'b0, 1'b1);
      end

      // Reset pulsed on line 2 while HS is active.
      do_reset();
      repeat (44) tick();
      chk("a_hs_active_before_reset", 32'(a_hs), 32'd0);
      RESET = 1'b1;
      tick();
      chk_a_reset("a_midreset");
      RESET = 1'b0;
      for (int unsigned n = 0; n < 4; n++) begin
         chk_a("a_after_reset", n, 1'b0, 1'b1);
         if (n < 3) tick();
      end

      // Reset during VS with SYNC_EN low: no frame-start pulse.
      repeat (79) tick();
      chk_a("a_vs_active", 82, 1'b0, 1'b1);
      SYNC_EN = 1'b0;
      RESET   = 1'b1;
      tick();
      chk_a_reset("a_vsreset");
      RESET = 1'b0;
      for (int unsigned n = 0; n < 4; n++) begin
         chk_a("a_nosync", n, 1'b0, 1'b0);
         tick();
      end
      SYNC_EN = 1'b1;

      // Table-driven replication / pattern vectors on instance B.
      for (int i = 0; i < 20; i++) begin
         MODE = tbl[i].mode;
         do_reset();
         repeat (tbl[i].cyc) tick();
         chk($sformatf("b_addr[%0d]", i), 32'(b_addr), 32'(tbl[i].addr));
         chk($sformatf("b_rgb[%0d]", i), 32'({b_r, b_g, b_b}),
             32'({tbl[i].r, tbl[i].g, tbl[i].b}));
         chk($sformatf("b_vis[%0d]", i), 32'(b_vis), 32'(tbl[i].vis));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_tx_engine.md
Name: vga_tx_engine

Overview:
- Parametrised successor to the fixed-timing VGA transmit path between the capture line buffer and the ADV DAC.
- Generates programmable H/V timing, issues line-buffer read addresses with integer pixel/line replication and ping-pong bank selection, and drives RGB from either the buffer or internal test patterns.
- Emits a frame-start pulse that the receive side uses for alignment.
- Sits in the TX clock domain; the line-buffer RAM is external with 1-cycle registered read.

Parameters:
- H_VISIBLE, 1024, active pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch
- V_VISIBLE, 768, active lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch
- HS_POL, 0, active level of VGA_HS
- VS_POL, 0, active level of VGA_VS
- PIX_REP, 2, output clocks per source pixel (1..8)
- LINE_REP, 2, output lines per source line (1..8)
- ADDR_W, 14, line-buffer address width; MSB is the bank bit
- DATA_W, 8, line-buffer data / colour channel width

Ports:
- CLK  in  1  TX pixel clock
- RESET  in  1  synchronous active-high reset
- ENABLE  in  1  counters advance only when high; outputs hold when low
- MODE  in  2  00 buffer grey, 01 colour bars, 10 grid, 11 black
- SYNC_EN  in  1  gates VGA_SYNC
- BRAM_ADDR  out  ADDR_W  line-buffer read address
- BRAM_DOUT  in  DATA_W  line-buffer read data, valid 1 clock after BRAM_ADDR
- VGA_R / VGA_G / VGA_B  out  DATA_W each  colour outputs
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- VGA_VISIBLE  out  1  high during active video, aligned with RGB
- VGA_SYNC  out  1  one-clock frame-start pulse

Behaviour:
- Counters: h_cnt 0..H_TOTAL-1, with H_TOTAL = sum of H_*; v_cnt 0..V_TOTAL-1, incremented when h_cnt wraps; v_cnt wraps to 0 after V_TOTAL-1.
- Active region: h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- HS asserted (HS_POL) when H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC. VS follows the same rule on v_cnt with the V_* parameters.
- Replication:
  - px_rep counter 0..PIX_REP-1 resets at h_cnt=0; src_x increments when px_rep wraps.
  - ln_rep counter 0..LINE_REP-1 resets at v_cnt=0; src_y increments when ln_rep wraps at end of line.
  - No divider is used.
- Address: BRAM_ADDR = {~src_y[0], src_x[ADDR_W-2:0]}. Reads come from the bank opposite the one RX is filling. src_x saturates at its maximum; it never wraps inside a line.
- Pipeline, total latency 2 clocks:
  - Stage 0: counters and BRAM_ADDR.
  - Stage 1: BRAM_DOUT arrives; HS, VS and visible are delayed 1.
  - Stage 2: RGB is registered; HS, VS and VISIBLE are delayed 2.
- RGB in stage 2:
  - Not visible: 0.
  - MODE 00: R=G=B=BRAM_DOUT.
  - MODE 01: 8 vertical bars, bar index = h_cnt*8/H_VISIBLE, computed as a registered bar counter stepping every H_VISIBLE/8 clocks. Bar index bits {2,1,0} select full-scale R, G, B.
  - MODE 10: all-ones where h_cnt[3:0]==0 or v_cnt[3:0]==0, else 0.
  - MODE 11: 0.
- MODE is captured into an internal register only at h_cnt=0, v_cnt=0. No mid-frame change takes effect.
- VGA_SYNC: high for exactly one clock, 2 clocks after the cycle with h_cnt=0 and v_cnt=0 and SYNC_EN=1; low otherwise.
- ENABLE low: counters, replication state and the pipeline freeze; outputs hold their last values. Resumes without a glitch.
- RESET (synchronous, active-high), effective on the next edge:
  - Counters and replication counters go to 0.
  - BRAM_ADDR becomes {1'b1, 0}.
  - RGB=0, VGA_VISIBLE=0, VGA_SYNC=0, HS=~HS_POL, VS=~VS_POL.
  - Captured MODE becomes 00.
  - Reset mid-frame restarts the frame at h_cnt=0; the first SYNC pulse follows 2 clocks after reset deasserts, if SYNC_EN is high.
- Counter widths: clog2 of H_TOTAL and V_TOTAL. All compares use full-width unsigned arithmetic.

Test Plan:
- Small timing (H 8/2/2/4, V 4/1/1/2, PIX_REP=1, LINE_REP=1), reset then run 2 frames -> HS low for h_cnt 10..11 every 16 clocks; VS low on lines 5; VISIBLE 8 clocks per line on lines 0..3; SYNC once per 128 clocks.
- MODE 00 with BRAM model returning data = addr[7:0], PIX_REP=2, LINE_REP=2 -> each source pixel appears on 2 consecutive clocks; BRAM_ADDR bank bit is 1,1,0,0 across lines 0..3; RGB lags BRAM_ADDR by 2 clocks.
- MODE 01 with H_VISIBLE=16 -> bars 2 clocks wide; bar 5 gives R=0xFF, G=0, B=0xFF; RGB=0 during blanking.
- Change MODE from 00 to 11 mid-frame -> output stays buffer data until the next frame start, then black.
- ENABLE low for 5 clocks mid-line -> all outputs frozen; after re-enable the sequence continues from the same h_cnt, with line length still 16 clocks.
- RESET pulsed at v_cnt=2 -> next clock HS/VS inactive and RGB=0; SYNC pulse 2 clocks after release; SYNC_EN=0 suppresses the pulse.
